// File: rtl/fabric_mmio_responder.sv
// Purpose : MMIO/scratch fabric target; queues RD/WR requests and answers each from a local word memory.
// Latency : request accepted in cycle N -> response valid in cycle N+3; 1 response per 2 cycles unstalled.
// Backpr. : ReqStall while the request FIFO is full; RspStall holds the response registers unchanged.
//
// Ports: clk/rst (sync, active-high); Req*Q502H request side (valid, opcode, byte address, data, thread ID);
//        ReqStall (FIFO full); Rsp*Q500H response side (valid, opcode, address, data, thread ID);
//        RspStall (downstream hold); ErrCount (saturating count of misses and illegal opcodes).

package fabric_mmio_pkg;
    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef struct packed {
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  tid;
    } req_t;
endpackage

// Purpose : generic synchronous FIFO with occupancy output.
// Latency : a pushed word is visible at head_dat_o the cycle after the push.
// Backpr. : pushes into a full FIFO and pops from an empty FIFO are ignored.
module fabric_mmio_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld_i,
    input  logic [W-1:0]       push_dat_i,
    input  logic               pop_i,
    output logic [W-1:0]       head_dat_o,
    output logic [$clog2(D):0] count_o
);
    localparam int AW = $clog2(D);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(D);

    logic [W-1:0]  store_q [D];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_vld_i && (cnt_q != CNT_FULL);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only entries covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = store_q[rd_ptr_q];
    assign count_o    = cnt_q;
endmodule

// Purpose : fabric MMIO responder top; FIFO in front of an IDLE/ACCESS/RESPOND serving FSM.
// Latency : accept at N -> RspValidQ500H at N+3; back-to-back responses every 2 cycles.
// Backpr. : ReqStall = FIFO full (no push that cycle); RspStall freezes RESPOND and all Rsp* fields.
module fabric_mmio_responder
    import fabric_mmio_pkg::*;
#(
    parameter int          MEM_AW    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          FIFO_D    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValidQ502H,
    input  t_opcode     ReqOpcodeQ502H,
    input  logic [31:0] ReqAddressQ502H,
    input  logic [31:0] ReqDataQ502H,
    input  logic [1:0]  ReqThreadIDQ502H,
    output logic        ReqStall,
    output logic        RspValidQ500H,
    output t_opcode     RspOpcodeQ500H,
    output logic [31:0] RspAddressQ500H,
    output logic [31:0] RspDataQ500H,
    output logic [1:0]  RspThreadIDQ500H,
    input  logic        RspStall,
    output logic [7:0]  ErrCount
);
    localparam int CW      = $clog2(FIFO_D) + 1;
    localparam int TAG_LSB = MEM_AW + 2;
    localparam logic [CW-1:0]      CNT_FULL = CW'(FIFO_D);
    localparam logic [31-TAG_LSB:0] BASE_TAG = BASE_ADDR[31:TAG_LSB];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t         state_q;
    req_t           cur_q;
    logic           rsp_vld_q;
    t_opcode        rsp_op_q;
    logic [31:0]    rsp_addr_q;
    logic [31:0]    rsp_data_q;
    logic [1:0]     rsp_tid_q;
    logic [7:0]     err_q;
    logic [7:0]     err_d;

    req_t           req_in;
    req_t           head;
    logic [CW-1:0]  fifo_cnt;
    logic           fifo_nonempty;
    logic           pop;

    logic [31:0]    mem_q [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic           hit;
    logic           is_rd;
    logic           is_wr;
    logic           req_err;
    logic [31:0]    mem_rdata;

    assign req_in = '{op: ReqOpcodeQ502H, addr: ReqAddressQ502H,
                      data: ReqDataQ502H, tid: ReqThreadIDQ502H};

    fabric_mmio_fifo #(
        .W ($bits(req_t)),
        .D (FIFO_D)
    ) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (ReqValidQ502H),
        .push_dat_i (req_in),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (fifo_cnt)
    );

    assign fifo_nonempty = (fifo_cnt != '0);
    // Stall reflects occupancy at the start of the cycle, so a same-cycle pop never frees a slot early.
    assign ReqStall      = (fifo_cnt == CNT_FULL);

    // The head is taken whenever the FSM is about to enter ACCESS: from IDLE, or on a completed handshake.
    assign pop = fifo_nonempty &&
                 ((state_q == S_IDLE) || ((state_q == S_RESPOND) && !RspStall));

    // Address decode on the latched request; byte-offset bits are ignored.
    assign hit       = (cur_q.addr[31:TAG_LSB] == BASE_TAG);
    assign idx       = cur_q.addr[MEM_AW+1:2];
    assign is_rd     = (cur_q.op == RD);
    assign is_wr     = (cur_q.op == WR);
    assign req_err   = !hit || !(is_rd || is_wr);
    assign mem_rdata = mem_q[idx];
    assign err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_op_q   <= RD;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_tid_q  <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_nonempty) begin
                        cur_q   <= head;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rsp_vld_q  <= 1'b1;
                    rsp_addr_q <= cur_q.addr;
                    rsp_tid_q  <= cur_q.tid;
                    if (is_rd) begin
                        rsp_op_q   <= RD_RSP;
                        rsp_data_q <= hit ? mem_rdata : 32'h0;
                    end else begin
                        // Writes and illegal opcodes both answer as WR_RSP with zero data.
                        rsp_op_q   <= WR_RSP;
                        rsp_data_q <= 32'h0;
                    end
                    if (req_err) begin
                        err_q <= err_d;
                    end
                    state_q <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (!RspStall) begin
                        rsp_vld_q  <= 1'b0;
                        rsp_op_q   <= RD;
                        rsp_addr_q <= '0;
                        rsp_data_q <= '0;
                        rsp_tid_q  <= '0;
                        if (fifo_nonempty) begin
                            cur_q   <= head;
                            state_q <= S_ACCESS;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Word memory is not reset; a write is suppressed if reset lands on its ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_ACCESS) && is_wr && hit) begin
            mem_q[idx] <= cur_q.data;
        end
    end

    assign RspValidQ500H    = rsp_vld_q;
    assign RspOpcodeQ500H   = rsp_op_q;
    assign RspAddressQ500H  = rsp_addr_q;
    assign RspDataQ500H     = rsp_data_q;
    assign RspThreadIDQ500H = rsp_tid_q;
    assign ErrCount         = err_q;
endmodule

// File: tb/tb_fabric_mmio_responder.sv
module tb_fabric_mmio_responder;
    import fabric_mmio_pkg::*;

    localparam int FIFO_D = 4;

    logic        clk;
    logic        rst;
    logic        ReqValidQ502H;
    t_opcode     ReqOpcodeQ502H;
    logic [31:0] ReqAddressQ502H;
    logic [31:0] ReqDataQ502H;
    logic [1:0]  ReqThreadIDQ502H;
    logic        ReqStall;
    logic        RspValidQ500H;
    t_opcode     RspOpcodeQ500H;
    logic [31:0] RspAddressQ500H;
    logic [31:0] RspDataQ500H;
    logic [1:0]  RspThreadIDQ500H;
    logic        RspStall;
    logic [7:0]  ErrCount;

    fabric_mmio_responder dut (
        .clk              (clk),
        .rst              (rst),
        .ReqValidQ502H    (ReqValidQ502H),
        .ReqOpcodeQ502H   (ReqOpcodeQ502H),
        .ReqAddressQ502H  (ReqAddressQ502H),
        .ReqDataQ502H     (ReqDataQ502H),
        .ReqThreadIDQ502H (ReqThreadIDQ502H),
        .ReqStall         (ReqStall),
        .RspValidQ500H    (RspValidQ500H),
        .RspOpcodeQ500H   (RspOpcodeQ500H),
        .RspAddressQ500H  (RspAddressQ500H),
        .RspDataQ500H     (RspDataQ500H),
        .RspThreadIDQ500H (RspThreadIDQ500H),
        .RspStall         (RspStall),
        .ErrCount         (ErrCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- behavioural model: accepted-request queue + word memory ----------------
    req_t        pend[$];
    logic [31:0] mmem [64];
    bit          mknown [64];
    int          merr = 0;
    bit          head_applied = 1'b0;
    t_opcode     e_op;
    logic [31:0] e_data;
    bit          e_data_known;

    // A request takes effect (memory, error count) once its response appears; requests are served in order.
    task automatic apply_head();
        req_t h;
        bit   hit;
        int   idx;
        bit   legal;
        h     = pend[0];
        hit   = (h.addr[31:8] == 24'h004000);
        idx   = int'(h.addr[7:2]);
        legal = (h.op == RD) || (h.op == WR);
        e_op  = (h.op == RD) ? RD_RSP : WR_RSP;
        e_data = 32'h0;
        e_data_known = 1'b1;
        if (h.op == RD && hit) begin
            e_data       = mmem[idx];
            e_data_known = mknown[idx];
        end
        if (h.op == WR && hit) begin
            mmem[idx]   = h.data;
            mknown[idx] = 1'b1;
        end
        if (!hit || !legal) merr = (merr < 255) ? merr + 1 : 255;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            head_applied = 1'b0;
            merr = 0;
        end else begin
            chk("occupancy", ((pend.size() > FIFO_D + 1) || (ReqStall && pend.size() < FIFO_D)) ? 1 : 0, 0);
            if (RspValidQ500H) begin
                if (pend.size() == 0) begin
                    chk("unexpected_rsp", RspValidQ500H, 0);
                end else begin
                    if (!head_applied) begin
                        apply_head();
                        head_applied = 1'b1;
                    end
                    chk("rsp_opcode", RspOpcodeQ500H, e_op);
                    chk("rsp_address", RspAddressQ500H, pend[0].addr);
                    chk("rsp_tid", RspThreadIDQ500H, pend[0].tid);
                    if (e_data_known) chk("rsp_data", RspDataQ500H, e_data);
                    chk("err_count", ErrCount, merr);
                    if (!RspStall) begin
                        void'(pend.pop_front());
                        head_applied = 1'b0;
                        rsp_cnt++;
                    end
                end
            end else begin
                chk("idle_fields_zero",
                    ((|RspOpcodeQ500H) || (|RspAddressQ500H) || (|RspDataQ500H) || (|RspThreadIDQ500H)) ? 1 : 0, 0);
            end
            if (ReqValidQ502H && !ReqStall) begin
                pend.push_back('{op: ReqOpcodeQ502H, addr: ReqAddressQ502H,
                                 data: ReqDataQ502H, tid: ReqThreadIDQ502H});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int          w_lat;
    bit          w_ok;
    t_opcode     w_op;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [1:0]  w_tid;
    logic [7:0]  w_err;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after a posedge; returns likewise once the request has been accepted.
    task automatic push(input t_opcode op, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        bit done;
        done = 1'b0;
        ReqValidQ502H    = 1'b1;
        ReqOpcodeQ502H   = op;
        ReqAddressQ502H  = a;
        ReqDataQ502H     = d;
        ReqThreadIDQ502H = t;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = !ReqStall;
            @(posedge clk);
            #1;
        end
        ReqValidQ502H    = 1'b0;
        ReqOpcodeQ502H   = RD;
        ReqAddressQ502H  = '0;
        ReqDataQ502H     = '0;
        ReqThreadIDQ502H = '0;
        if (!done) timeout_fail("push_accept");
    endtask

    task automatic wait_rsp(input int base, input int bound);
        w_ok  = 1'b0;
        w_lat = base;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            w_lat++;
            if (RspValidQ500H) begin
                w_ok   = 1'b1;
                w_op   = RspOpcodeQ500H;
                w_addr = RspAddressQ500H;
                w_data = RspDataQ500H;
                w_tid  = RspThreadIDQ500H;
                w_err  = ErrCount;
                break;
            end
        end
        if (!w_ok) timeout_fail("wait_rsp");
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int k = 0; k < bound && !done; k++) begin
            @(negedge clk);
            done = (pend.size() == 0) && !RspValidQ500H;
        end
        if (!done) timeout_fail("drain");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   acc;
    logic stall_c4;
    logic stall_c5;
    int   rc0;
    bit   stall_run;

    initial begin
        rst = 1'b1;
        ReqValidQ502H = 1'b0; ReqOpcodeQ502H = RD; ReqAddressQ502H = '0;
        ReqDataQ502H = '0; ReqThreadIDQ502H = '0; RspStall = 1'b0;
        for (int i = 0; i < 64; i++) mknown[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", RspValidQ500H, 0);
        chk("reset_req_stall", ReqStall, 0);
        chk("reset_err_count", ErrCount, 0);
        chk("reset_rsp_fields", {RspAddressQ500H, RspDataQ500H}, 0);
        sync();
        rst = 1'b0;

        // Test 1: WR then RD to the same word, latency and back-to-back spacing
        ReqValidQ502H = 1'b1; ReqOpcodeQ502H = WR; ReqAddressQ502H = 32'h0040_0010;
        ReqDataQ502H = 32'hCAFE_F00D; ReqThreadIDQ502H = 2'd1;
        sync();
        ReqOpcodeQ502H = RD; ReqDataQ502H = 32'h0; ReqThreadIDQ502H = 2'd2;
        sync();
        ReqValidQ502H = 1'b0;
        wait_rsp(1, 20);
        chk("t1_wr_latency", w_lat, 3);
        chk("t1_wr_opcode", w_op, WR_RSP);
        chk("t1_wr_data", w_data, 32'h0);
        chk("t1_wr_tid", w_tid, 2'd1);
        chk("t1_wr_addr", w_addr, 32'h0040_0010);
        wait_rsp(w_lat, 20);
        chk("t1_rd_latency", w_lat, 5);
        chk("t1_rd_opcode", w_op, RD_RSP);
        chk("t1_rd_data", w_data, 32'hCAFE_F00D);
        chk("t1_rd_tid", w_tid, 2'd2);
        chk("t1_err", w_err, 0);
        drain(50);

        // Test 2: six back-to-back pushes with downstream stalled
        sync();
        rc0 = rsp_cnt;
        RspStall = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            ReqValidQ502H = 1'b1; ReqOpcodeQ502H = WR;
            ReqAddressQ502H = 32'h0040_0020 + 32'(4 * i);
            ReqDataQ502H = 32'h1000 + 32'(i); ReqThreadIDQ502H = 2'(i);
            @(negedge clk);
            if (!ReqStall) acc++;
            if (i == 4) stall_c4 = ReqStall;
            if (i == 5) stall_c5 = ReqStall;
            @(posedge clk);
            #1;
        end
        ReqValidQ502H = 1'b0;
        chk("t2_accepted", acc, 5);
        chk("t2_stall_before_full", stall_c4, 0);
        chk("t2_stall_when_full", stall_c5, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t2_held_valid", RspValidQ500H, 1);
        chk("t2_held_addr", RspAddressQ500H, 32'h0040_0020);
        chk("t2_still_full", ReqStall, 1);
        sync();
        RspStall = 1'b0;
        drain(100);
        chk("t2_rsp_count", rsp_cnt - rc0, 5);

        // Test 3: out-of-range accesses leave memory alone and bump ErrCount
        sync();
        push(WR, 32'h0040_0000, 32'h1234_5678, 2'd0);
        wait_rsp(0, 20);
        sync();
        push(RD, 32'h0050_0000, 32'h0, 2'd3);
        wait_rsp(0, 20);
        chk("t3_miss_opcode", w_op, RD_RSP);
        chk("t3_miss_data", w_data, 32'h0);
        chk("t3_err_after_miss", w_err, 1);
        sync();
        push(WR, 32'h0050_0000, 32'hDEAD_BEEF, 2'd1);
        wait_rsp(0, 20);
        sync();
        push(RD, 32'h0040_0000, 32'h0, 2'd2);
        wait_rsp(0, 20);
        chk("t3_mem_unchanged", w_data, 32'h1234_5678);
        chk("t3_err_after_two", w_err, 2);
        drain(50);

        // Test 4: reset with one response held in RESPOND and three requests buffered
        sync();
        RspStall = 1'b1;
        for (int i = 0; i < 4; i++) push(RD, 32'h0040_0000, 32'h0, 2'(i));
        @(negedge clk);
        chk("t4_in_respond", RspValidQ500H, 1);
        rc0 = rsp_cnt;
        sync();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_rst_valid", RspValidQ500H, 0);
        chk("t4_rst_stall", ReqStall, 0);
        chk("t4_rst_err", ErrCount, 0);
        sync();
        rst = 1'b0;
        RspStall = 1'b0;
        repeat (20) @(posedge clk);
        chk("t4_no_late_rsp", rsp_cnt - rc0, 0);

        // Test 5: 300 erroneous requests saturate ErrCount; illegal opcode at a hit address writes nothing
        sync();
        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) push(WR_RSP, 32'h0040_0010, 32'h0000_0BAD, 2'(i));
            else if (i % 3 == 1) push(RD, 32'h0050_0000 + 32'(4 * i), 32'h0, 2'(i));
            else push(WR, 32'h8000_0000 + 32'(4 * i), 32'(i), 2'(i));
        end
        drain(3000);
        chk("t5_err_saturated", ErrCount, 8'hFF);
        sync();
        push(RD, 32'h0040_0010, 32'h0, 2'd3);
        wait_rsp(0, 20);
        chk("t5_illegal_no_write", w_data, 32'hCAFE_F00D);
        chk("t5_err_still_sat", w_err, 8'hFF);
        drain(50);

        // Test 6: random RD/WR mix under random RspStall against the model
        sync();
        stall_run = 1'b1;
        fork
            begin
                while (stall_run) begin
                    @(posedge clk);
                    #1;
                    RspStall = ($urandom_range(0, 3) == 0);
                end
            end
            begin
                for (int i = 0; i < 64; i++) push(WR, 32'h0040_0000 + 32'(4 * i), $urandom, 2'(i));
                for (int i = 0; i < 300; i++) begin
                    int          r;
                    logic [31:0] a;
                    r = int'($urandom_range(0, 19));
                    a = 32'h0040_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                    if (r < 9) push(RD, a, 32'h0, 2'($urandom_range(0, 3)));
                    else if (r < 17) push(WR, a, $urandom, 2'($urandom_range(0, 3)));
                    else if (r < 19) push(RD, a | 32'h0100_0000, 32'h0, 2'($urandom_range(0, 3)));
                    else push(RD_RSP, a, $urandom, 2'($urandom_range(0, 3)));
                end
                drain(4000);
                stall_run = 1'b0;
            end
        join
        RspStall = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
